dac_write_arbiter: RTL
======================

// Module: dac_write_arbiter
// PURPOSE
//  Shares the 4-channel DAC sample/volume register file between Soundrive (ZX bus port writes)
//  and General Sound (GS memory-read DAC strobes, GS volume port writes).
//  Each source is buffered in its own small FIFO, so back-to-back or simultaneous writes are never lost.
//  Round-robin arbitration issues at most one sample write per clk32 cycle to the DAC register file.
//  Sits between the bus decoders (sd_dacN_wr / gs_dacN_wr strobes) and the PWM/volume DAC counters.
// PARAMETERS
//  FIFO_DEPTH  4   entries per source FIFO (power of 2, >=2)
//  CHN_W       2   channel index width (4 DAC channels)
//  DW          8   sample width
//  VW          6   volume width
// PORTS
//  clk32       in   1      system clock, 32 MHz
//  rst_n       in   1      async reset, active low
//  sd_ena      in   1      Soundrive enable (cfg); low = SD FIFO flushed, sd_req ignored
//  gs_ena      in   1      GS enable (cfg); low = GS FIFO and volume holding register flushed
//  sd_req      in   1      one-cycle Soundrive write strobe (already edge-detected)
//  sd_chn      in   CHN_W  SD channel index {a[6],a[4]}
//  sd_data     in   DW     SD sample, offset-binary as written by the Z80
//  gs_req      in   1      one-cycle GS DAC write strobe
//  gs_chn      in   CHN_W  GS channel index ga[9:8]
//  gs_data     in   DW     GS sample
//  gs_vol_req  in   1      one-cycle GS volume write strobe (ports 6..9)
//  gs_vol_chn  in   CHN_W  GS volume channel
//  gs_vol      in   VW     GS volume value
//  ovf_clr     in   1      clears both sticky overflow flags
//  dac_we      out  1      one-cycle sample write to DAC register file
//  dac_chn     out  CHN_W  target channel for dac_we
//  dac_val     out  DW     converted sample: d[7] ? d : {d[7],~d[6:0]}
//  vol_we      out  1      one-cycle volume write
//  vol_chn     out  CHN_W  target channel for vol_we
//  vol_val     out  VW     volume value
//  sd_ovf      out  1      sticky: SD request dropped (FIFO full)
//  gs_ovf      out  1      sticky: GS request dropped (FIFO full)
// BEHAVIOUR
//  - Reset: all outputs 0, FIFOs empty, last_grant=GS (so SD wins the first contention), vol holder empty.
//  - Push: a req sampled at edge k stores {chn,data} in the source FIFO at edge k; push is accepted when
//    !full OR a pop of the same FIFO happens at that edge (full+push+pop -> count unchanged).
//  - Full+push without pop: entry dropped, xx_ovf set at edge k; ovf_clr wins over a same-cycle set.
//  - Arbitration (combinational on registered FIFO state): one source non-empty -> grant it;
//    both non-empty -> grant the source != last_grant; last_grant updated only on a grant.
//  - Output registered: the granted head is popped and dac_we/dac_chn/dac_val are driven at edge k+1.
//    Min latency req->dac_we = 2 edges. Sustained throughput = 1 write/cycle across both sources.
//  - SD grant also forces the channel's volume to max: vol_we=1, vol_chn=sd chn, vol_val=6'h3F, same cycle.
//  - GS volume: 1-entry holding register. A new gs_vol_req overwrites a still-held value (last wins,
//    no overflow flag). Issued on vol_we when the volume port is not taken by an SD grant in that
//    cycle; otherwise held. SD forced volume always has priority on the volume port.
//  - Same channel written by both sources: applied in grant order; the later write wins.
//  - dac_we/vol_we are deasserted in every cycle with no grant; dac_chn/dac_val hold their last values.
//  - sd_ena/gs_ena low: the FIFO pointers of that source are cleared synchronously and never granted;
//    an in-flight output already registered still completes.
//  - rst_n assertion mid-operation: immediate clear; no partial write appears after release.
//  - FIFO pointers wrap modulo FIFO_DEPTH; count width is log2(FIFO_DEPTH)+1.
// STRUCTURE
//  - Shared package (zxms_pkg): CHN_W, DW, VW, VOL_MAX=6'h3F, function dac_conv(d) (offset->sign-mag).
//  - Sub-module: sample_fifo (sync FIFO, width CHN_W+DW, push/pop/full/empty/flush), instantiated x2.
//  - Top: arbiter + last_grant, output registers, GS volume holder, overflow flags.
// TESTING
//  1. sd_req chn=2 data=8'h80 -> 2 edges later dac_we=1 chn=2 val=8'h80; same cycle vol_we=1 chn=2 val=3F.
//  2. sd_req and gs_req in the same cycle (sd chn0 8'h00, gs chn0 8'hC0) -> SD write (val 8'h7F) then
//     GS write (val 8'hC0) on consecutive cycles; final channel 0 value 8'hC0.
//  3. 5 SD reqs back-to-back with GS FIFO holding 4 entries -> 5th SD push accepted only if a pop coincides;
//     otherwise sd_ovf=1; ovf_clr pulse -> sd_ovf=0.
//  4. gs_vol_req chn3 vol=6'h15 while SD entries are streaming -> vol_we chn3=15 deferred to the first
//     cycle with no SD grant; second gs_vol_req before issue (vol=6'h20) -> only 6'h20 is issued.
//  5. Fill both FIFOs, then pulse sd_ena=0 -> SD entries discarded, only GS writes are emitted,
//     sd_ovf unchanged.
//  6. Assert rst_n low with both FIFOs non-empty -> all outputs 0 immediately; after release no dac_we
//     until a new req.

Source files
------------

// File: rtl/zxms_pkg.sv
// Shared types and constants for the DAC write path.
// Sample conversion turns Z80 offset-binary into the DAC's sign-magnitude form.
package zxms_pkg;

   localparam int CHN_W = 2;
   localparam int DW = 8;
   localparam int VW = 6;

   localparam logic [VW-1:0] VOL_MAX = 6'h3F;

   typedef enum logic {
      SRC_SD = 1'b0,
      SRC_GS = 1'b1
   } src_t;

   typedef struct packed {
      logic [CHN_W-1:0] chn;
      logic [DW-1:0]    data;
   } fifo_ent_t;

   function automatic logic [DW-1:0] dac_conv(input logic [DW-1:0] d);
      return d[DW-1] ? d : {d[DW-1], ~d[DW-2:0]};
   endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO for one write source.
// A push into a full FIFO is still taken when a pop frees the slot at the same edge.
module sample_fifo #(
   parameter int DEPTH = 4,
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         empty,
   output logic         drop
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;
   logic [W-1:0]  mem [DEPTH];
   logic          full;
   logic          push_ok;
   logic          pop_ok;

   assign full = (cnt == (AW+1)'(DEPTH));
   assign empty = (cnt == '0);
   assign pop_ok = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign drop = push & full & ~pop_ok & ~flush;
   assign dout = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)
            rd_ptr <= rd_ptr + AW'(1);
         unique case ({push_ok, pop_ok})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok && !flush)
         mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/dac_write_arbiter.sv
// Round-robin merge of Soundrive and General Sound writes into the DAC register file.
// SD grants also force that channel's volume to max; GS volume waits for a free volume slot.
module dac_write_arbiter
   import zxms_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk32,
   input  logic             rst_n,
   input  logic             sd_ena,
   input  logic             gs_ena,
   input  logic             sd_req,
   input  logic [CHN_W-1:0] sd_chn,
   input  logic [DW-1:0]    sd_data,
   input  logic             gs_req,
   input  logic [CHN_W-1:0] gs_chn,
   input  logic [DW-1:0]    gs_data,
   input  logic             gs_vol_req,
   input  logic [CHN_W-1:0] gs_vol_chn,
   input  logic [VW-1:0]    gs_vol,
   input  logic             ovf_clr,
   output logic             dac_we,
   output logic [CHN_W-1:0] dac_chn,
   output logic [DW-1:0]    dac_val,
   output logic             vol_we,
   output logic [CHN_W-1:0] vol_chn,
   output logic [VW-1:0]    vol_val,
   output logic             sd_ovf,
   output logic             gs_ovf
);

   localparam int FW = CHN_W + DW;

   fifo_ent_t        sd_head;
   fifo_ent_t        gs_head;
   logic             sd_empty;
   logic             gs_empty;
   logic             sd_drop;
   logic             gs_drop;
   logic             sd_avail;
   logic             gs_avail;
   logic             gnt_sd;
   logic             gnt_gs;
   logic             gnt_any;
   src_t             last_grant;
   logic             hold_vld;
   logic [CHN_W-1:0] hold_chn;
   logic [VW-1:0]    hold_val;
   logic             vol_issue;

   sample_fifo #(
      .DEPTH(FIFO_DEPTH),
      .W    (FW)
   ) u_sd_fifo (
      .clk  (clk32),
      .rst_n(rst_n),
      .flush(~sd_ena),
      .push (sd_req & sd_ena),
      .pop  (gnt_sd),
      .din  ({sd_chn, sd_data}),
      .dout (sd_head),
      .empty(sd_empty),
      .drop (sd_drop)
   );

   sample_fifo #(
      .DEPTH(FIFO_DEPTH),
      .W    (FW)
   ) u_gs_fifo (
      .clk  (clk32),
      .rst_n(rst_n),
      .flush(~gs_ena),
      .push (gs_req & gs_ena),
      .pop  (gnt_gs),
      .din  ({gs_chn, gs_data}),
      .dout (gs_head),
      .empty(gs_empty),
      .drop (gs_drop)
   );

   assign sd_avail = ~sd_empty & sd_ena;
   assign gs_avail = ~gs_empty & gs_ena;
   assign gnt_any = gnt_sd | gnt_gs;

   always_comb begin
      gnt_sd = 1'b0;
      gnt_gs = 1'b0;
      unique case (1'b1)
         (sd_avail & gs_avail): begin
            gnt_sd = (last_grant == SRC_GS);
            gnt_gs = (last_grant == SRC_SD);
         end
         (sd_avail & ~gs_avail): gnt_sd = 1'b1;
         (~sd_avail & gs_avail): gnt_gs = 1'b1;
         default: ;
      endcase
   end

   // The volume port is free only when no SD grant claims it.
   assign vol_issue = hold_vld & gs_ena & ~gnt_sd;

   always_ff @(posedge clk32 or negedge rst_n) begin
      if (!rst_n)
         last_grant <= SRC_GS;
      else if (gnt_any)
         last_grant <= gnt_sd ? SRC_SD : SRC_GS;
   end

   always_ff @(posedge clk32 or negedge rst_n) begin
      if (!rst_n) begin
         dac_we <= 1'b0;
         dac_chn <= '0;
         dac_val <= '0;
      end else begin
         dac_we <= gnt_any;
         if (gnt_sd) begin
            dac_chn <= sd_head.chn;
            dac_val <= dac_conv(sd_head.data);
         end else if (gnt_gs) begin
            dac_chn <= gs_head.chn;
            dac_val <= dac_conv(gs_head.data);
         end
      end
   end

   always_ff @(posedge clk32 or negedge rst_n) begin
      if (!rst_n) begin
         vol_we <= 1'b0;
         vol_chn <= '0;
         vol_val <= '0;
      end else begin
         vol_we <= gnt_sd | vol_issue;
         if (gnt_sd) begin
            vol_chn <= sd_head.chn;
            vol_val <= VOL_MAX;
         end else if (vol_issue) begin
            vol_chn <= hold_chn;
            vol_val <= hold_val;
         end
      end
   end

   // A newer volume write simply replaces an unissued one.
   always_ff @(posedge clk32 or negedge rst_n) begin
      if (!rst_n) begin
         hold_vld <= 1'b0;
         hold_chn <= '0;
         hold_val <= '0;
      end else if (!gs_ena) begin
         hold_vld <= 1'b0;
      end else if (gs_vol_req) begin
         hold_vld <= 1'b1;
         hold_chn <= gs_vol_chn;
         hold_val <= gs_vol;
      end else if (vol_issue) begin
         hold_vld <= 1'b0;
      end
   end

   always_ff @(posedge clk32 or negedge rst_n) begin
      if (!rst_n) begin
         sd_ovf <= 1'b0;
         gs_ovf <= 1'b0;
      end else begin
         if (ovf_clr)
            sd_ovf <= 1'b0;
         else if (sd_drop)
            sd_ovf <= 1'b1;
         if (ovf_clr)
            gs_ovf <= 1'b0;
         else if (gs_drop)
            gs_ovf <= 1'b1;
      end
   end

endmodule
